spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Arbiter and sequencer that shares the single SPI transaction engine (flash and PSRAM behind one set of SPI pins) between the core's instruction-fetch port and data port. It sits between `rv32i_core` and the SPI engine inside the memory controller path. It decodes each address to a target chip, serializes requests one at a time, and enforces fairness so instruction fetch is not starved. It also returns a bus error on decode failure or backend timeout.

## Interface

Parameters:

- FLASH_BASE_ADDR, 32'h00000000: flash region; matched on addr[31:24].
- PSRAM_BASE_ADDR, 32'h01000000: PSRAM region; matched on addr[31:24].
- MAX_DATA_RUN, 4: consecutive data grants allowed while fetch is pending.
- TIMEOUT_CYCLES, 1024: WAIT-state cycles before a transaction is aborted.

Ports:

- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- i_instr_req, in, 1: fetch request; held with stable address until o_instr_ready.
- i_instr_addr, in, 32: fetch address.
- o_instr_data, out, 32: fetch data; valid with o_instr_ready.
- o_instr_ready, out, 1: one-cycle completion pulse.
- i_mem_re, in, 1: data read request; held until o_mem_ready.
- i_mem_we, in, 1: data write request; held until o_mem_ready.
- i_mem_addr, in, 32: data address.
- i_mem_wdata, in, 32: data to write.
- i_mem_flag, in, 3: access size/sign, passed through unchanged.
- o_mem_rdata, out, 32: read data; valid with o_mem_ready.
- o_mem_ready, out, 1: one-cycle completion pulse.
- o_spi_start, out, 1: one-cycle transaction launch.
- o_spi_sel, out, 1: target chip; 0 = flash, 1 = PSRAM.
- o_spi_we, out, 1: write transaction.
- o_spi_addr, out, 24: address offset, taken from addr[23:0].
- o_spi_wdata, out, 32: write data.
- o_spi_flag, out, 3: access size/sign.
- o_spi_abort, out, 1: one-cycle abort on timeout.
- i_spi_done, in, 1: backend completion pulse.
- i_spi_rdata, in, 32: read data; valid with i_spi_done.
- o_bus_error, out, 1: one-cycle pulse, coincident with the errored ready.

## Operation

State machine: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner and latch its address, wdata, flag, we, and an owner bit.
  - Decode the address:
    - addr[31:24] == FLASH_BASE_ADDR[31:24] selects sel = 0.
    - addr[31:24] == PSRAM_BASE_ADDR[31:24] selects sel = 1.
    - Any other address is a decode error.
    - A write to flash is a decode error.
    - On decode error, go to RESP with the error flag set and rdata = 32'hFFFFFFFF.
  - Otherwise go to ISSUE.
- **ISSUE:** o_spi_start = 1 for exactly this cycle, then go to WAIT.
- **WAIT:** the timeout counter increments each cycle.
  - On i_spi_done, latch i_spi_rdata and go to RESP.
  - When the counter reaches TIMEOUT_CYCLES-1 without done, pulse o_spi_abort, set the error flag, force rdata = 32'hFFFFFFFF, and go to RESP.
- **RESP:** pulse the owner's ready (o_instr_ready or o_mem_ready) with its data, plus o_bus_error if the error flag is set, then go to IDLE.
- **Arbitration:** data wins by default.
  - `data_run` increments on each data grant made while i_instr_req is also pending.
  - `data_run` clears on every fetch grant, and on any data grant made while fetch is idle.
  - When data_run == MAX_DATA_RUN and fetch is pending, fetch wins.
- **Data request:** the data port is requesting when (i_mem_re | i_mem_we). If both re and we are high, treat the access as a write.
- **Outputs:** o_spi_addr, o_spi_sel, o_spi_we, o_spi_wdata and o_spi_flag are driven from registers and stay stable from ISSUE through WAIT. The ready data outputs hold their last value between pulses.

## Timing

- **Reset values:** all outputs are 0; state = IDLE; data_run = 0; timeout counter = 0.
- **Reset mid-transaction:** return to IDLE next edge with no ready, abort or error pulse.
- **Minimum latency:** request sampled in IDLE at cycle 0, start at cycle 1, done at cycle 2 at the earliest, ready at cycle 3.
- **Decode-error latency:** ready/error pulse at cycle 1.
- **Request sampling:** requests are sampled only in IDLE. A requester sees ready at edge N and may change or drop its request before edge N+1, which the IDLE state then samples.
- **Done and timeout in the same cycle:** done wins, with no abort or error.
- **i_spi_done outside WAIT:** ignored.
- **Throughput:** at most one outstanding transaction; no overlap between requesters.
- **Counter width:** the timeout counter must hold TIMEOUT_CYCLES-1 and must not wrap.

## Test plan

- **Simple PSRAM read:** i_mem_re at addr 32'h01000010, backend done 5 cycles after start with rdata 32'hDEADBEEF. Expect o_spi_sel = 1, o_spi_addr = 24'h000010, o_mem_ready 1 cycle after done, o_mem_rdata = 32'hDEADBEEF.
- **Simultaneous requests:** fetch at 32'h00000100 and data read at 32'h01000000 both held continuously, MAX_DATA_RUN = 4. Expect grant order D, D, D, D, I, D, ..., never more than 4 data grants between fetches.
- **Write to flash:** i_mem_we at 32'h00000040. Expect no o_spi_start, o_mem_ready and o_bus_error both in cycle 1.
- **Unmapped fetch:** fetch from 32'h20000000. Expect o_instr_ready with o_instr_data = 32'hFFFFFFFF and o_bus_error.
- **Timeout:** TIMEOUT_CYCLES = 16, backend never asserts done. Expect o_spi_abort, then o_mem_ready with o_bus_error, exactly 16 WAIT cycles after start. Repeat with done on the final WAIT cycle and expect a normal completion.
- **Reset during WAIT:** rst asserted for 1 cycle while in WAIT. Expect all outputs 0 the next cycle, no ready pulse, and a subsequent request serviced normally.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Purpose: shares one SPI transaction engine between instruction fetch and data port, with address decode and error return.
// Latency: request sampled in IDLE -> start next cycle -> ready one cycle after done; decode errors complete in 1 cycle.
// Backpressure: requesters hold req/addr until their ready pulse; one transaction outstanding; data wins unless fetch has waited MAX_DATA_RUN grants.
module spi_bus_arbiter #(
  parameter logic [31:0] FLASH_BASE_ADDR = 32'h00000000,
  parameter logic [31:0] PSRAM_BASE_ADDR = 32'h01000000,
  parameter int          MAX_DATA_RUN    = 4,
  parameter int          TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        i_instr_req,
  input  logic [31:0] i_instr_addr,
  output logic [31:0] o_instr_data,
  output logic        o_instr_ready,
  // data port
  input  logic        i_mem_re,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [2:0]  i_mem_flag,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_ready,
  // SPI engine side
  output logic        o_spi_start,
  output logic        o_spi_sel,
  output logic        o_spi_we,
  output logic [23:0] o_spi_addr,
  output logic [31:0] o_spi_wdata,
  output logic [2:0]  o_spi_flag,
  output logic        o_spi_abort,
  input  logic        i_spi_done,
  input  logic [31:0] i_spi_rdata,
  // error report, coincident with the errored ready
  output logic        o_bus_error
);

  // Counter sized to hold TIMEOUT_CYCLES-1; it never needs to go past that value.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Run counter sized to hold MAX_DATA_RUN itself.
  localparam int RUN_W = (MAX_DATA_RUN > 0) ? $clog2(MAX_DATA_RUN + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
  // Fetches are always full-word reads.
  localparam logic [2:0]       FETCH_FLAG = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q,       state_d;
  logic [RUN_W-1:0]  data_run_q,    data_run_d;
  logic [CNT_W-1:0]  tmo_cnt_q,     tmo_cnt_d;
  logic              owner_mem_q,   owner_mem_d;
  logic              spi_start_q,   spi_start_d;
  logic              spi_sel_q,     spi_sel_d;
  logic              spi_we_q,      spi_we_d;
  logic [23:0]       spi_addr_q,    spi_addr_d;
  logic [31:0]       spi_wdata_q,   spi_wdata_d;
  logic [2:0]        spi_flag_q,    spi_flag_d;
  logic              spi_abort_q,   spi_abort_d;
  logic              instr_ready_q, instr_ready_d;
  logic [31:0]       instr_data_q,  instr_data_d;
  logic              mem_ready_q,   mem_ready_d;
  logic [31:0]       mem_rdata_q,   mem_rdata_d;
  logic              bus_error_q,   bus_error_d;

  logic        instr_pend;
  logic        data_pend;
  logic        grant_instr;
  logic        grant_data;
  logic [31:0] cand_addr;
  logic [31:0] cand_wdata;
  logic [2:0]  cand_flag;
  logic        cand_we;
  logic        hit_flash;
  logic        hit_psram;
  logic        dec_err;

  logic        resp_fire;
  logic        resp_err;
  logic        resp_to_mem;
  logic [31:0] resp_data;

  // Arbitration and address decode of the candidate request (only acted on in IDLE).
  always_comb begin
    instr_pend  = i_instr_req;
    data_pend   = i_mem_re | i_mem_we;
    // Fetch wins only when it is alone or data has used up its run.
    grant_instr = instr_pend && (!data_pend || (data_run_q >= RUN_MAX));
    grant_data  = data_pend && !grant_instr;

    cand_addr   = grant_instr ? i_instr_addr : i_mem_addr;
    cand_wdata  = grant_instr ? 32'h0        : i_mem_wdata;
    cand_flag   = grant_instr ? FETCH_FLAG   : i_mem_flag;
    // re and we together is treated as a write.
    cand_we     = grant_instr ? 1'b0         : i_mem_we;

    hit_flash   = (cand_addr[31:24] == FLASH_BASE_ADDR[31:24]);
    hit_psram   = (cand_addr[31:24] == PSRAM_BASE_ADDR[31:24]);
    // Flash is read-only from this port, so a flash write is rejected here.
    dec_err     = !(hit_flash || hit_psram) || (hit_flash && cand_we);
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    data_run_d    = data_run_q;
    tmo_cnt_d     = tmo_cnt_q;
    owner_mem_d   = owner_mem_q;
    spi_sel_d     = spi_sel_q;
    spi_we_d      = spi_we_q;
    spi_addr_d    = spi_addr_q;
    spi_wdata_d   = spi_wdata_q;
    spi_flag_d    = spi_flag_q;
    instr_data_d  = instr_data_q;
    mem_rdata_d   = mem_rdata_q;
    // pulse outputs default low
    spi_start_d   = 1'b0;
    spi_abort_d   = 1'b0;
    instr_ready_d = 1'b0;
    mem_ready_d   = 1'b0;
    bus_error_d   = 1'b0;

    resp_fire     = 1'b0;
    resp_err      = 1'b0;
    resp_to_mem   = owner_mem_q;
    resp_data     = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (grant_instr || grant_data) begin
          owner_mem_d = grant_data;
          spi_sel_d   = ~hit_flash;
          spi_we_d    = cand_we;
          spi_addr_d  = cand_addr[23:0];
          spi_wdata_d = cand_wdata;
          spi_flag_d  = cand_flag;

          // Run length only grows while fetch is actually being held off.
          if (grant_data && instr_pend) begin
            data_run_d = data_run_q + 1'b1;
          end else begin
            data_run_d = '0;
          end

          if (dec_err) begin
            resp_fire   = 1'b1;
            resp_err    = 1'b1;
            resp_data   = 32'hFFFF_FFFF;
            resp_to_mem = grant_data;
          end else begin
            state_d     = S_ISSUE;
            spi_start_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        state_d   = S_WAIT;
        tmo_cnt_d = '0;
      end

      S_WAIT: begin
        // done has priority over a timeout landing in the same cycle
        if (i_spi_done) begin
          resp_fire = 1'b1;
          resp_data = i_spi_rdata;
        end else if (tmo_cnt_q == CNT_LAST) begin
          resp_fire   = 1'b1;
          resp_err    = 1'b1;
          resp_data   = 32'hFFFF_FFFF;
          spi_abort_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Route the completion to whichever port owns the transaction.
    if (resp_fire) begin
      state_d     = S_RESP;
      bus_error_d = resp_err;
      if (resp_to_mem) begin
        mem_ready_d = 1'b1;
        mem_rdata_d = resp_data;
      end else begin
        instr_ready_d = 1'b1;
        instr_data_d  = resp_data;
      end
    end
  end

  // State and registered outputs; reset clears everything so no pulse leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      data_run_q    <= '0;
      tmo_cnt_q     <= '0;
      owner_mem_q   <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_sel_q     <= 1'b0;
      spi_we_q      <= 1'b0;
      spi_addr_q    <= '0;
      spi_wdata_q   <= '0;
      spi_flag_q    <= '0;
      spi_abort_q   <= 1'b0;
      instr_ready_q <= 1'b0;
      instr_data_q  <= '0;
      mem_ready_q   <= 1'b0;
      mem_rdata_q   <= '0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_run_q    <= data_run_d;
      tmo_cnt_q     <= tmo_cnt_d;
      owner_mem_q   <= owner_mem_d;
      spi_start_q   <= spi_start_d;
      spi_sel_q     <= spi_sel_d;
      spi_we_q      <= spi_we_d;
      spi_addr_q    <= spi_addr_d;
      spi_wdata_q   <= spi_wdata_d;
      spi_flag_q    <= spi_flag_d;
      spi_abort_q   <= spi_abort_d;
      instr_ready_q <= instr_ready_d;
      instr_data_q  <= instr_data_d;
      mem_ready_q   <= mem_ready_d;
      mem_rdata_q   <= mem_rdata_d;
      bus_error_q   <= bus_error_d;
    end
  end

  assign o_spi_start   = spi_start_q;
  assign o_spi_sel     = spi_sel_q;
  assign o_spi_we      = spi_we_q;
  assign o_spi_addr    = spi_addr_q;
  assign o_spi_wdata   = spi_wdata_q;
  assign o_spi_flag    = spi_flag_q;
  assign o_spi_abort   = spi_abort_q;
  assign o_instr_ready = instr_ready_q;
  assign o_instr_data  = instr_data_q;
  assign o_mem_ready   = mem_ready_q;
  assign o_mem_rdata   = mem_rdata_q;
  assign o_bus_error   = bus_error_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a short timeout so the abort path is reachable.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
// Each scenario task carries its own inline comparisons.
module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_instr_req = 1'b0;
  logic [31:0] i_instr_addr = 32'h0;
  logic [31:0] o_instr_data;
  logic        o_instr_ready;
  logic        i_mem_re = 1'b0;
  logic        i_mem_we = 1'b0;
  logic [31:0] i_mem_addr = 32'h0;
  logic [31:0] i_mem_wdata = 32'h0;
  logic [2:0]  i_mem_flag = 3'b0;
  logic [31:0] o_mem_rdata;
  logic        o_mem_ready;
  logic        o_spi_start;
  logic        o_spi_sel;
  logic        o_spi_we;
  logic [23:0] o_spi_addr;
  logic [31:0] o_spi_wdata;
  logic [2:0]  o_spi_flag;
  logic        o_spi_abort;
  logic        i_spi_done = 1'b0;
  logic [31:0] i_spi_rdata = 32'h0;
  logic        o_bus_error;

  int errors = 0;
  int checks = 0;

  logic [129:0] all_outs;
  assign all_outs = {o_instr_data, o_instr_ready, o_mem_rdata, o_mem_ready, o_spi_start,
                     o_spi_sel, o_spi_we, o_spi_addr, o_spi_wdata, o_spi_flag,
                     o_spi_abort, o_bus_error};

  spi_bus_arbiter #(
    .FLASH_BASE_ADDR(32'h00000000),
    .PSRAM_BASE_ADDR(32'h01000000),
    .MAX_DATA_RUN   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_instr_req  (i_instr_req),
    .i_instr_addr (i_instr_addr),
    .o_instr_data (o_instr_data),
    .o_instr_ready(o_instr_ready),
    .i_mem_re     (i_mem_re),
    .i_mem_we     (i_mem_we),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .i_mem_flag   (i_mem_flag),
    .o_mem_rdata  (o_mem_rdata),
    .o_mem_ready  (o_mem_ready),
    .o_spi_start  (o_spi_start),
    .o_spi_sel    (o_spi_sel),
    .o_spi_we     (o_spi_we),
    .o_spi_addr   (o_spi_addr),
    .o_spi_wdata  (o_spi_wdata),
    .o_spi_flag   (o_spi_flag),
    .o_spi_abort  (o_spi_abort),
    .i_spi_done   (i_spi_done),
    .i_spi_rdata  (i_spi_rdata),
    .o_bus_error  (o_bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until o_spi_start is seen, within a bounded number of cycles.
  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_spi_start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_idle_outputs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_psram_read();
    int bad;
    i_mem_re   = 1'b1;
    i_mem_addr = 32'h01000010;
    i_mem_flag = 3'b101;
    tick();  // cycle 1
    checks++;
    if (o_spi_start !== 1'b1) begin
      errors++;
      $display("FAIL rd_start: got %b expected 1", o_spi_start);
    end
    checks++;
    if ({o_spi_sel, o_spi_we, o_spi_addr} !== {1'b1, 1'b0, 24'h000010}) begin
      errors++;
      $display("FAIL rd_sel_we_addr: got %b %b %h expected 1 0 000010", o_spi_sel, o_spi_we, o_spi_addr);
    end
    checks++;
    if (o_spi_flag !== 3'b101) begin
      errors++;
      $display("FAIL rd_flag: got %b expected 101", o_spi_flag);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin  // cycles 2..6
      tick();
      if (o_spi_start || o_mem_ready || o_spi_addr !== 24'h000010 || o_spi_sel !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rd_wait_stable: got %0d bad cycles expected 0", bad);
    end
    i_spi_done  = 1'b1;
    i_spi_rdata = 32'hDEADBEEF;
    tick();  // cycle 7
    i_spi_done  = 1'b0;
    i_spi_rdata = 32'h0;
    checks++;
    if ({o_mem_ready, o_instr_ready, o_bus_error} !== 3'b100) begin
      errors++;
      $display("FAIL rd_ready: got %b expected 100", {o_mem_ready, o_instr_ready, o_bus_error});
    end
    checks++;
    if (o_mem_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_data: got %h expected deadbeef", o_mem_rdata);
    end
    i_mem_re = 1'b0;
    tick();
    checks++;
    if ({o_mem_ready, o_mem_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL rd_hold: got %b %h expected 0 deadbeef", o_mem_ready, o_mem_rdata);
    end
  endtask

  task automatic test_psram_write();
    i_mem_re    = 1'b1;
    i_mem_we    = 1'b1;
    i_mem_addr  = 32'h01000008;
    i_mem_wdata = 32'hCAFEF00D;
    i_mem_flag  = 3'b010;
    tick();
    checks++;
    if ({o_spi_start, o_spi_sel, o_spi_we, o_spi_addr} !== {1'b1, 1'b1, 1'b1, 24'h000008}) begin
      errors++;
      $display("FAIL wr_start_fields: got %b%b%b %h expected 111 000008", o_spi_start, o_spi_sel, o_spi_we, o_spi_addr);
    end
    checks++;
    if (o_spi_wdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL wr_wdata: got %h expected cafef00d", o_spi_wdata);
    end
    tick();
    i_spi_done = 1'b1;
    tick();
    i_spi_done = 1'b0;
    checks++;
    if ({o_mem_ready, o_bus_error} !== 2'b10) begin
      errors++;
      $display("FAIL wr_ready: got %b expected 10", {o_mem_ready, o_bus_error});
    end
    i_mem_re = 1'b0;
    i_mem_we = 1'b0;
    tick();
  endtask

  task automatic test_write_flash();
    i_mem_we   = 1'b1;
    i_mem_addr = 32'h00000040;
    tick();
    checks++;
    if ({o_spi_start, o_mem_ready, o_bus_error} !== 3'b011) begin
      errors++;
      $display("FAIL flash_wr_err: got %b expected 011", {o_spi_start, o_mem_ready, o_bus_error});
    end
    checks++;
    if (o_mem_rdata !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL flash_wr_rdata: got %h expected ffffffff", o_mem_rdata);
    end
    i_mem_we = 1'b0;
    tick();
    checks++;
    if ({o_spi_start, o_mem_ready, o_bus_error} !== 3'b000) begin
      errors++;
      $display("FAIL flash_wr_after: got %b expected 000", {o_spi_start, o_mem_ready, o_bus_error});
    end
  endtask

  task automatic test_unmapped_fetch();
    i_instr_req  = 1'b1;
    i_instr_addr = 32'h20000000;
    tick();
    checks++;
    if ({o_instr_ready, o_bus_error, o_mem_ready, o_spi_start} !== 4'b1100) begin
      errors++;
      $display("FAIL unmapped_pulses: got %b expected 1100", {o_instr_ready, o_bus_error, o_mem_ready, o_spi_start});
    end
    checks++;
    if (o_instr_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL unmapped_data: got %h expected ffffffff", o_instr_data);
    end
    i_instr_req = 1'b0;
    tick();
  endtask

  task automatic test_done_outside_wait();
    i_spi_done  = 1'b1;
    i_spi_rdata = 32'h11111111;
    tick();
    tick();
    i_spi_done  = 1'b0;
    checks++;
    if ({o_instr_ready, o_mem_ready, o_bus_error, o_spi_abort} !== 4'b0000) begin
      errors++;
      $display("FAIL stray_done: got %b expected 0000", {o_instr_ready, o_mem_ready, o_bus_error, o_spi_abort});
    end
  endtask

  task automatic test_timeout();
    int early;
    // backend silent: 16 WAIT cycles, then abort + errored ready
    i_mem_re   = 1'b1;
    i_mem_addr = 32'h01000020;
    tick();
    checks++;
    if (o_spi_start !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start: got %b expected 1", o_spi_start);
    end
    early = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i < 17 && (o_mem_ready || o_spi_abort || o_bus_error)) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL tmo_early: got %0d early pulses expected 0", early);
    end
    checks++;
    if ({o_spi_abort, o_mem_ready, o_bus_error} !== 3'b111) begin
      errors++;
      $display("FAIL tmo_abort: got %b expected 111", {o_spi_abort, o_mem_ready, o_bus_error});
    end
    checks++;
    if (o_mem_rdata !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL tmo_rdata: got %h expected ffffffff", o_mem_rdata);
    end
    i_mem_re = 1'b0;
    tick();

    // done on the final WAIT cycle must win over the timeout
    i_mem_re   = 1'b1;
    i_mem_addr = 32'h01000024;
    tick();
    early = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (o_mem_ready || o_spi_abort || o_bus_error) early++;
    end
    i_spi_done  = 1'b1;
    i_spi_rdata = 32'h13579BDF;
    tick();
    i_spi_done  = 1'b0;
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL tmo_last_early: got %0d early pulses expected 0", early);
    end
    checks++;
    if ({o_spi_abort, o_mem_ready, o_bus_error} !== 3'b010) begin
      errors++;
      $display("FAIL tmo_last_done: got %b expected 010", {o_spi_abort, o_mem_ready, o_bus_error});
    end
    checks++;
    if (o_mem_rdata !== 32'h13579BDF) begin
      errors++;
      $display("FAIL tmo_last_data: got %h expected 13579bdf", o_mem_rdata);
    end
    i_mem_re = 1'b0;
    tick();
  endtask

  task automatic test_reset_wait();
    i_mem_re   = 1'b1;
    i_mem_addr = 32'h01000004;
    tick();  // ISSUE
    tick();  // WAIT
    tick();  // WAIT
    rst         = 1'b1;
    i_spi_done  = 1'b1;
    i_spi_rdata = 32'h77777777;
    tick();
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs: got %h expected 0", all_outs);
    end
    rst        = 1'b0;
    i_spi_done = 1'b0;
    tick();  // held request is sampled again
    checks++;
    if ({o_spi_start, o_spi_sel, o_spi_addr} !== {1'b1, 1'b1, 24'h000004}) begin
      errors++;
      $display("FAIL rst_wait_restart: got %b%b %h expected 11 000004", o_spi_start, o_spi_sel, o_spi_addr);
    end
    tick();  // first WAIT cycle: minimum-latency done
    i_spi_done  = 1'b1;
    i_spi_rdata = 32'hA5A5A5A5;
    tick();
    i_spi_done  = 1'b0;
    checks++;
    if ({o_mem_ready, o_bus_error, o_mem_rdata} !== {1'b1, 1'b0, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL rst_wait_service: got %b%b %h expected 10 a5a5a5a5", o_mem_ready, o_bus_error, o_mem_rdata);
    end
    i_mem_re = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit seen;
    bit exp_instr;
    i_instr_req  = 1'b1;
    i_instr_addr = 32'h00000100;
    i_mem_re     = 1'b1;
    i_mem_addr   = 32'h01000000;
    for (int n = 0; n < 10; n++) begin
      // with a run limit of 4 the grant pattern is D D D D I repeating
      exp_instr = ((n % 5) == 4);
      wait_start(seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL b2b_start_%0d: got no start expected start within 20 cycles", n);
        break;
      end
      checks++;
      if ({o_spi_sel, o_spi_addr} !== (exp_instr ? {1'b0, 24'h000100} : {1'b1, 24'h000000})) begin
        errors++;
        $display("FAIL b2b_grant_%0d: got sel %b addr %h expected %s", n, o_spi_sel, o_spi_addr, exp_instr ? "fetch" : "data");
      end
      tick();
      i_spi_done  = 1'b1;
      i_spi_rdata = 32'h100 + n;
      tick();
      i_spi_done  = 1'b0;
      checks++;
      if ({o_instr_ready, o_mem_ready} !== (exp_instr ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL b2b_ready_%0d: got %b expected %b", n, {o_instr_ready, o_mem_ready}, exp_instr ? 2'b10 : 2'b01);
      end
      checks++;
      if ((exp_instr ? o_instr_data : o_mem_rdata) !== 32'h100 + n) begin
        errors++;
        $display("FAIL b2b_data_%0d: got %h expected %h", n, exp_instr ? o_instr_data : o_mem_rdata, 32'h100 + n);
      end
      tick();
    end
    i_instr_req = 1'b0;
    i_mem_re    = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_psram_read();
    test_psram_write();
    test_write_flash();
    test_unmapped_fetch();
    test_done_outside_wait();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
